// File: rtl/fetch_queue.sv
// Instruction fetch unit: issues single outstanding memory requests and buffers
// returned instructions with their PCs in a small circular queue for decode.
module fetch_queue #(
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 4,
  parameter logic [DATA_W-1:0]  PC_RESET = 16'h0000
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [DATA_W-1:0]          imem_addr,
  input  logic                       imem_ack,
  input  logic [DATA_W-1:0]          imem_data,
  input  logic                       redirect,
  input  logic [DATA_W-1:0]          redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [DATA_W-1:0]          inst,
  output logic [DATA_W-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       halted,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALTED} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               push, pop, halt_op;

  logic [DATA_W-1:0]  inst_mem_q [DEPTH];
  logic [DATA_W-1:0]  pc_mem_q   [DEPTH];

  assign halt_op = (imem_data[15:11] == 5'b00000);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = (count_q != '0) && inst_ready && !redirect;

    case (state_q)
      IDLE: begin
        if (imem_ack) err_d = 1'b1;
        if (count_q < CNT_W'(DEPTH)) begin
          state_d = WAIT;
          addr_d  = pc_q;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + DATA_W'(2);
          state_d = halt_op ? HALTED : IDLE;
        end
      end
      DROP: begin
        if (imem_ack) state_d = IDLE;
      end
      HALTED: begin
        if (imem_ack) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Redirect wins over ack and pop; an unanswered request must still be drained.
    if (redirect) begin
      push    = 1'b0;
      pc_d    = redirect_pc;
      state_d = ((state_q == WAIT || state_q == DROP) && !imem_ack) ? DROP : IDLE;
      if (redirect_pc[0]) err_d = 1'b1;
    end

    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RESET;
      addr_q  <= PC_RESET;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Entry storage needs no reset: it is only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[tail_q] <= imem_data;
      pc_mem_q[tail_q]   <= pc_q;
    end
  end

  assign imem_req   = (state_q == WAIT) || (state_q == DROP);
  assign imem_addr  = addr_q;
  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? inst_mem_q[head_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[head_q]   : '0;
  assign count      = count_q;
  assign halted     = (state_q == HALTED);
  assign err        = err_q;

endmodule
